// File: rtl/memory_col_ctrl_pkg.sv
// Shared types for the memory column controller: FSM state encoding and
// the column data width. Imported by the interface and the controller.
package mem_col_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    RWAIT = 3'd2,
    RESP  = 3'd3,
    VWAIT = 3'd4
  } mem_col_state_t;

  localparam int MEM_COL_DATA_W = 8;

endpackage

// File: rtl/memory_col_ctrl_if.sv
// Bundle of request, response, column and error signals of memory_col_ctrl.
// slave  : the controller side.
// master : the environment side (requester plus the attached column).
interface memory_col_ctrl_if
  import mem_col_pkg::*;
#(
  parameter int ADDR_W = 10
);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [ADDR_W-1:0]         req_addr;
  logic [MEM_COL_DATA_W-1:0] req_wdata;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [MEM_COL_DATA_W-1:0] rsp_rdata;

  logic [ADDR_W-1:0]         mem_addr;
  logic [MEM_COL_DATA_W-1:0] mem_wr_data;
  logic                      mem_byte_en;
  logic [MEM_COL_DATA_W-1:0] mem_rd_data;

  logic                      wr_err;
  logic [ADDR_W-1:0]         err_addr;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rd_data,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_data, mem_byte_en,
           wr_err, err_addr
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_data, mem_byte_en,
           wr_err, err_addr
  );

endinterface

// File: rtl/memory_col_ctrl.sv
// memory_col_ctrl: single-request front-end for one memory column.
// Accepts one read or write at a time, strobes the column for one cycle on
// writes, waits RD_LAT edges on reads and holds the response until taken.
// Optional macro MEM_COL_WR_VERIFY_EN adds a read-back check after every
// write with a sticky wr_err flag and the address of the first mismatch.
module memory_col_ctrl
  import mem_col_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  memory_col_ctrl_if.slave    bus
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  mem_col_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic [MEM_COL_DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                      mem_byte_en_q, mem_byte_en_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [MEM_COL_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef MEM_COL_WR_VERIFY_EN
  logic                      wr_err_q, wr_err_d;
  logic [ADDR_W-1:0]         err_addr_q, err_addr_d;
`endif

  // Control and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_byte_en_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_byte_en_q <= mem_byte_en_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

`ifdef MEM_COL_WR_VERIFY_EN
  // Sticky write-verify error flag and first-mismatch address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_q   <= 1'b0;
      err_addr_q <= '0;
    end else begin
      wr_err_q   <= wr_err_d;
      err_addr_q <= err_addr_d;
    end
  end
`endif

  // Next-state and registered-output logic of the request FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_byte_en_d = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
`ifdef MEM_COL_WR_VERIFY_EN
    wr_err_d      = wr_err_q;
    err_addr_d    = err_addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          mem_addr_d = bus.req_addr;
          if (bus.req_we) begin
            mem_wr_data_d = bus.req_wdata;
            mem_byte_en_d = 1'b1;
            state_d       = WRITE;
          end else begin
            cnt_d   = CNT_W'(RD_LAT);
            state_d = RWAIT;
          end
        end
      end
      WRITE: begin
        // Column samples the strobe on this edge; address stays put so the
        // optional read-back sees the same location.
`ifdef MEM_COL_WR_VERIFY_EN
        cnt_d   = CNT_W'(RD_LAT);
        state_d = VWAIT;
`else
        state_d = IDLE;
`endif
      end
      RWAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_rdata_d = bus.mem_rd_data;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
`ifdef MEM_COL_WR_VERIFY_EN
      VWAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (bus.mem_rd_data != mem_wr_data_q) begin
            wr_err_d = 1'b1;
            if (!wr_err_q) err_addr_d = mem_addr_q;
          end
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.mem_byte_en = mem_byte_en_q;
`ifdef MEM_COL_WR_VERIFY_EN
  assign bus.wr_err      = wr_err_q;
  assign bus.err_addr    = err_addr_q;
`else
  assign bus.wr_err      = 1'b0;
  assign bus.err_addr    = '0;
`endif

endmodule

// File: tb/tb_memory_col_ctrl.sv
// Testbench for memory_col_ctrl (ADDR_W=10, RD_LAT=2) with a column model.
// Honours MEM_COL_WR_VERIFY_EN for the write-turnaround and error checks.
module tb_memory_col_ctrl;
  import mem_col_pkg::*;

  localparam int ADDR_W = 10;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef MEM_COL_WR_VERIFY_EN
  localparam int WR_BUSY = 1 + RD_LAT;
`else
  localparam int WR_BUSY = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_col_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  memory_col_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Column model: one-cycle strobe write, read data valid RD_LAT edges after
  // the address as seen by the controller (RD_LAT-1 register stages).
  logic [7:0]        col_mem [DEPTH] = '{default: 8'h00};
  logic [7:0]        rd_q;
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  always @(posedge clk) begin
    if (bus.mem_byte_en)
      col_mem[bus.mem_addr] <= (corrupt_en && bus.mem_addr == corrupt_addr) ?
                               ~bus.mem_wr_data : bus.mem_wr_data;
    rd_q <= col_mem[bus.mem_addr];
  end
  assign bus.mem_rd_data = rd_q;

  // Reference: what a read of each address should return.
  logic [7:0] exp_mem [DEPTH];

  task automatic issue(input logic we, input logic [ADDR_W-1:0] a,
                       input logic [7:0] d, output bit ok);
    ok = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    if (ok && we) exp_mem[a] = d;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout addr=%0h: req_ready never seen, required within 50 cycles", a);
    end
  endtask

  task automatic wait_rsp(output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout: rsp_valid never seen, required within 40 cycles");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 00", bus.rsp_rdata); end
    n_cmp++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    n_cmp++; if (bus.mem_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wr_data got %h want 00", bus.mem_wr_data); end
    n_cmp++; if (bus.mem_byte_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_byte_en got %b want 0", bus.mem_byte_en); end
    n_cmp++; if (bus.wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err got %b want 0", bus.wr_err); end
    n_cmp++; if (bus.err_addr !== '0) begin n_fail++; $display("FAIL reset_err_addr got %h want 0", bus.err_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_single;
    bit ok;
    issue(1'b1, 10'd3, 8'hA5, ok);
    n_cmp++; if (bus.mem_byte_en !== 1'b1) begin n_fail++; $display("FAIL wr_strobe got %b want 1", bus.mem_byte_en); end
    n_cmp++; if (bus.mem_addr !== 10'd3) begin n_fail++; $display("FAIL wr_addr got %h want 003", bus.mem_addr); end
    n_cmp++; if (bus.mem_wr_data !== 8'hA5) begin n_fail++; $display("FAIL wr_data got %h want a5", bus.mem_wr_data); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL wr_bubble got %b want 0", bus.req_ready); end
    for (int i = 1; i < WR_BUSY; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.req_ready !== 1'b0 || bus.mem_byte_en !== 1'b0) begin
        n_fail++; $display("FAIL wr_busy cyc%0d got ready=%b strobe=%b want 0/0", i, bus.req_ready, bus.mem_byte_en); end
    end
    @(posedge clk); #1;
    n_cmp++; if (bus.mem_byte_en !== 1'b0) begin n_fail++; $display("FAIL wr_strobe_fall got %b want 0", bus.mem_byte_en); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_back got %b want 1", bus.req_ready); end
  endtask

  task automatic test_read_single;
    bit ok; int cyc;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 10'd3, 8'h00, ok);
    wait_rsp(cyc, ok);
    n_cmp++; if (cyc != RD_LAT) begin n_fail++; $display("FAIL rd_latency got %0d want %0d", cyc, RD_LAT); end
    n_cmp++; if (bus.rsp_rdata !== exp_mem[3]) begin n_fail++; $display("FAIL rd_data got %h want %h", bus.rsp_rdata, exp_mem[3]); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd_drain got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok; int cyc;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 10'd3, 8'h00, ok);
    wait_rsp(cyc, ok);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'hA5 || bus.req_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cyc%0d got valid=%b data=%h ready=%b want 1/a5/0", i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready); end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'd3;
    @(posedge clk); #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept got ready=%b want 0", bus.req_ready); end
    wait_rsp(cyc, ok);
    n_cmp++; if (bus.rsp_rdata !== 8'hA5) begin n_fail++; $display("FAIL bp_next_data got %h want a5", bus.rsp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    bit ok; bit seen; logic [7:0] keep;
    bus.rsp_ready = 1'b1;
    issue(1'b0, 10'd3, 8'h00, ok);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_addr !== '0) begin
      n_fail++; $display("FAIL rst_rwait got ready=%b valid=%b addr=%h want 1/0/0", bus.req_ready, bus.rsp_valid, bus.mem_addr); end
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL rst_no_rsp got rsp_valid=1 want 0"); end
    keep = exp_mem[5];
    issue(1'b1, 10'd5, 8'h11, ok);
    exp_mem[5] = keep;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.mem_byte_en !== 1'b0 || bus.mem_wr_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_write got strobe=%b data=%h want 0/00", bus.mem_byte_en, bus.mem_wr_data); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    bit ok; int cyc; int dly;
    logic [ADDR_W-1:0] a, b; logic [7:0] d;
    bus.rsp_ready = 1'b1;
    issue(1'b1, 10'd1023, 8'hFF, ok);
    issue(1'b0, 10'd1023, 8'h00, ok);
    wait_rsp(cyc, ok);
    n_cmp++; if (bus.rsp_rdata !== 8'hFF) begin n_fail++; $display("FAIL b2b_top_addr got %h want ff", bus.rsp_rdata); end
    issue(1'b1, 10'd0, 8'h00, ok);
    issue(1'b0, 10'd0, 8'h00, ok);
    wait_rsp(cyc, ok);
    n_cmp++; if (bus.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL b2b_addr0 got %h want 00", bus.rsp_rdata); end
    for (int i = 0; i < 100; i++) begin
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      d = 8'($urandom);
      issue(1'b1, a, d, ok);
      n_cmp++; if (bus.mem_byte_en !== 1'b1 || bus.mem_addr !== a || bus.mem_wr_data !== d) begin
        n_fail++; $display("FAIL rnd_wr%0d got en=%b addr=%h data=%h want 1/%h/%h", i, bus.mem_byte_en, bus.mem_addr, bus.mem_wr_data, a, d); end
      b = ($urandom_range(0, 1) == 0) ? a : ADDR_W'($urandom_range(0, DEPTH - 1));
      dly = $urandom_range(0, 3);
      bus.rsp_ready = (dly == 0);
      issue(1'b0, b, 8'h00, ok);
      wait_rsp(cyc, ok);
      n_cmp++; if (bus.rsp_rdata !== exp_mem[b] || cyc != RD_LAT) begin
        n_fail++; $display("FAIL rnd_rd%0d addr=%h got data=%h lat=%0d want %h/%0d", i, b, bus.rsp_rdata, cyc, exp_mem[b], RD_LAT); end
      repeat (dly) begin @(posedge clk); #1; end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wr_verify;
    bit ok;
    bus.rsp_ready = 1'b1;
    corrupt_en = 1'b1;
    corrupt_addr = 10'h155;
    issue(1'b1, 10'h155, 8'h3C, ok);
    repeat (WR_BUSY) @(posedge clk);
    #1;
`ifdef MEM_COL_WR_VERIFY_EN
    n_cmp++; if (bus.wr_err !== 1'b1 || bus.err_addr !== 10'h155) begin
      n_fail++; $display("FAIL verify_first got err=%b addr=%h want 1/155", bus.wr_err, bus.err_addr); end
`else
    n_cmp++; if (bus.wr_err !== 1'b0 || bus.err_addr !== '0) begin
      n_fail++; $display("FAIL verify_off got err=%b addr=%h want 0/000", bus.wr_err, bus.err_addr); end
`endif
    corrupt_addr = 10'd7;
    issue(1'b1, 10'd7, 8'h42, ok);
    repeat (WR_BUSY + 4) @(posedge clk);
    #1;
`ifdef MEM_COL_WR_VERIFY_EN
    n_cmp++; if (bus.wr_err !== 1'b1 || bus.err_addr !== 10'h155) begin
      n_fail++; $display("FAIL verify_sticky got err=%b addr=%h want 1/155", bus.wr_err, bus.err_addr); end
`else
    n_cmp++; if (bus.wr_err !== 1'b0 || bus.err_addr !== '0) begin
      n_fail++; $display("FAIL verify_off2 got err=%b addr=%h want 0/000", bus.wr_err, bus.err_addr); end
`endif
    corrupt_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write_single();
    test_read_single();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_wr_verify();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
